// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 1-bit prediction per entry.
// Answers IF-stage lookups combinationally and carries the answer into ID.
module branch_target_buffer #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] pc_if,
  input  logic        stall,
  input  logic        flush,
  input  logic        Wrt,
  input  logic        Wrp,
  input  logic        equal,
  input  logic [31:0] branch_target,
  output logic [1:0]  Hp,
  output logic [31:0] pred_target,
  output logic [1:0]  Hpd,
  output logic [31:0] pc_id,
  output logic [15:0] flush_count
);

  localparam int unsigned IDX  = $clog2(ENTRIES);
  localparam int unsigned TAGW = 32 - IDX - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [ENTRIES-1:0] r_pred;
  logic [TAGW-1:0]    r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];

  logic [1:0]  r_hpd;
  logic [31:0] r_pc_id;
  logic [15:0] r_flush_cnt;

  logic [IDX-1:0]  w_if_idx;
  logic [TAGW-1:0] w_if_tag;
  logic [IDX-1:0]  w_id_idx;
  logic [TAGW-1:0] w_id_tag;
  logic            w_hit;
  logic            w_take;
  logic            w_id_match;

  assign w_if_idx = pc_if[IDX+1:2];
  assign w_if_tag = pc_if[31:IDX+2];
  assign w_id_idx = r_pc_id[IDX+1:2];
  assign w_id_tag = r_pc_id[31:IDX+2];

  // Lookup: no bypass of same-edge writes, so reads see only committed state.
  assign w_hit       = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_take      = w_hit && r_pred[w_if_idx];
  assign Hp          = {w_hit, w_take};
  assign pred_target = w_take ? r_target[w_if_idx] : pc_if + 32'd4;

  // Prediction rewrite is dropped if an aliasing branch has evicted the entry.
  assign w_id_match = r_valid[w_id_idx] && (r_tag[w_id_idx] == w_id_tag);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid  <= '0;
      r_pred   <= '0;
      r_tag    <= '{default: '0};
      r_target <= '{default: '0};
    end else if (Wrt) begin
      r_valid[w_id_idx]  <= 1'b1;
      r_pred[w_id_idx]   <= equal;
      r_tag[w_id_idx]    <= w_id_tag;
      r_target[w_id_idx] <= branch_target;
    end else if (Wrp && w_id_match) begin
      r_pred[w_id_idx] <= equal;
    end
  end

  // IF/ID pipeline copy: flush beats stall.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hpd   <= 2'b00;
      r_pc_id <= 32'd0;
    end else if (flush) begin
      r_hpd   <= 2'b00;
      r_pc_id <= 32'd0;
    end else if (!stall) begin
      r_hpd   <= Hp;
      r_pc_id <= pc_if;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_flush_cnt <= 16'd0;
    end else if (flush && (r_flush_cnt != 16'hFFFF)) begin
      r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign Hpd         = r_hpd;
  assign pc_id       = r_pc_id;
  assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Randomized and directed bench for branch_target_buffer against a behavioural model.
module tb_branch_target_buffer;

  localparam int ENTRIES = 16;
  localparam int IDX     = 4;

  logic        clock;
  logic        reset_n;
  logic [31:0] pc_if;
  logic        stall;
  logic        flush;
  logic        Wrt;
  logic        Wrp;
  logic        equal;
  logic [31:0] branch_target;
  logic [1:0]  Hp;
  logic [31:0] pred_target;
  logic [1:0]  Hpd;
  logic [31:0] pc_id;
  logic [15:0] flush_count;

  branch_target_buffer #(.ENTRIES(ENTRIES)) dut (
    .clock(clock), .reset_n(reset_n), .pc_if(pc_if), .stall(stall), .flush(flush),
    .Wrt(Wrt), .Wrp(Wrp), .equal(equal), .branch_target(branch_target),
    .Hp(Hp), .pred_target(pred_target), .Hpd(Hpd), .pc_id(pc_id),
    .flush_count(flush_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  bit          m_valid  [ENTRIES];
  bit          m_pred   [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  logic [1:0]  m_hpd;
  logic [31:0] m_pc_id;
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_pred[i] = 0; m_tag[i] = '0; m_target[i] = '0;
    end
    m_hpd = 2'b00; m_pc_id = '0; m_cnt = '0;
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'(ENTRIES));
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX + 2);
  endfunction

  task automatic lookup(input logic [31:0] pc, output logic [1:0] hp, output logic [31:0] pt);
    int i;
    bit h, p;
    i  = idx_of(pc);
    h  = m_valid[i] && (m_tag[i] == tag_of(pc));
    p  = h && m_pred[i];
    hp = {h, p};
    pt = p ? m_target[i] : pc + 32'd4;
  endtask

  // One clock: drive after negedge, check before posedge, advance model at posedge.
  task automatic cycle(input logic [31:0] pc, input logic st, input logic fl,
                       input logic wt, input logic wp, input logic eq,
                       input logic [31:0] bt);
    logic [1:0]  ehp;
    logic [31:0] ept;
    int          i;
    pc_if = pc; stall = st; flush = fl; Wrt = wt; Wrp = wp; equal = eq; branch_target = bt;
    #1;
    lookup(pc, ehp, ept);
    check("Hp", {30'd0, Hp}, {30'd0, ehp});
    check("pred_target", pred_target, ept);
    check("Hpd", {30'd0, Hpd}, {30'd0, m_hpd});
    check("pc_id", pc_id, m_pc_id);
    check("flush_count", {16'd0, flush_count}, {16'd0, m_cnt});
    @(posedge clock);
    i = idx_of(m_pc_id);
    if (wt) begin
      m_valid[i] = 1; m_tag[i] = tag_of(m_pc_id); m_target[i] = bt; m_pred[i] = eq;
    end else if (wp && m_valid[i] && m_tag[i] == tag_of(m_pc_id)) begin
      m_pred[i] = eq;
    end
    if (fl) begin
      m_hpd = 2'b00; m_pc_id = '0;
    end else if (!st) begin
      m_hpd = ehp; m_pc_id = pc;
    end
    if (fl && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    @(negedge clock);
  endtask

  task automatic idle(input logic [31:0] pc);
    cycle(pc, 0, 0, 0, 0, 0, 32'd0);
  endtask

  // Explicit spot check of the lookup for a given PC, before the next cycle is driven.
  task automatic peek(input string tag, input logic [31:0] pc,
                      input logic [1:0] exp_hp, input logic [31:0] exp_pt);
    pc_if = pc; Wrt = 0; Wrp = 0;
    #1;
    check({tag, "_hp"}, {30'd0, Hp}, {30'd0, exp_hp});
    check({tag, "_pt"}, pred_target, exp_pt);
  endtask

  initial begin
    logic [31:0] pc;
    reset_n = 0; pc_if = '0; stall = 0; flush = 0; Wrt = 0; Wrp = 0; equal = 0;
    branch_target = '0;
    reset_model();
    @(negedge clock); @(negedge clock);
    reset_n = 1;

    // Reset state and first miss
    peek("reset_miss", 32'h0040_0010, 2'b00, 32'h0040_0014);
    check("reset_hpd", {30'd0, Hpd}, 32'd0);
    check("reset_cnt", {16'd0, flush_count}, 32'd0);
    idle(32'h0040_0010);
    check("first_pc_id", pc_id, 32'h0040_0010);
    check("first_hpd", {30'd0, Hpd}, 32'd0);

    // Allocate taken branch; same cycle still sees the old (miss) contents
    cycle(32'h0040_0010, 0, 0, 1, 0, 1, 32'h0040_0100);
    peek("alloc", 32'h0040_0010, 2'b11, 32'h0040_0100);

    // Prediction flip
    cycle(32'h0040_0010, 0, 0, 0, 1, 0, 32'd0);
    peek("flip", 32'h0040_0010, 2'b10, 32'h0040_0014);

    // Alias guard: Wrp from an aliasing pc_id is ignored
    idle(32'h0040_0050);
    cycle(32'h0040_0050, 0, 0, 0, 1, 1, 32'd0);
    peek("alias_other", 32'h0040_0050, 2'b00, 32'h0040_0054);
    peek("alias_keep", 32'h0040_0010, 2'b10, 32'h0040_0014);

    // Stall holds IF/ID for 3 edges
    idle(32'h0040_0010);
    cycle(32'h0040_0020, 1, 0, 0, 0, 0, 32'd0);
    cycle(32'h0040_0024, 1, 0, 0, 0, 0, 32'd0);
    cycle(32'h0040_0028, 1, 0, 0, 0, 0, 32'd0);
    check("stall_pc_id", pc_id, 32'h0040_0010);
    check("stall_hpd", {30'd0, Hpd}, 32'd2);

    // Stall with flush: flush wins
    cycle(32'h0040_002C, 1, 1, 0, 0, 0, 32'd0);
    check("sf_pc_id", pc_id, 32'd0);
    check("sf_hpd", {30'd0, Hpd}, 32'd0);
    check("sf_cnt", {16'd0, flush_count}, 32'd1);

    // Same-cycle hazard at index 4
    idle(32'h0040_0090);
    cycle(32'h0040_0010, 0, 0, 1, 0, 1, 32'h0000_1234);
    peek("hazard_evicted", 32'h0040_0010, 2'b00, 32'h0040_0014);
    peek("hazard_new", 32'h0040_0090, 2'b11, 32'h0000_1234);

    // Wrap-around on miss
    peek("wrap", 32'hFFFF_FFFC, 2'b00, 32'h0000_0000);
    idle(32'hFFFF_FFFC);

    // Randomized traffic over a small aliasing PC pool
    for (int n = 0; n < 600; n++) begin
      pc = 32'h0040_0000 + (32'($urandom_range(0, 63)) << 2);
      cycle(pc, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
            1'($urandom), {$urandom, 2'b00} >> 0);
    end

    // Flush counter saturation
    for (int n = 0; n < 70000; n++) cycle(32'h0040_0090, 0, 1, 0, 0, 0, 32'd0);
    check("sat_cnt", {16'd0, flush_count}, 32'h0000_FFFF);
    cycle(32'h0040_0090, 0, 1, 0, 0, 0, 32'd0);
    check("sat_hold", {16'd0, flush_count}, 32'h0000_FFFF);

    // Make index 4 hold a taken entry, then reset asynchronously between edges
    cycle(32'h0040_0090, 0, 0, 0, 0, 0, 32'd0);
    cycle(32'h0040_0090, 0, 0, 1, 0, 1, 32'h0000_4444);
    peek("pre_reset", 32'h0040_0090, 2'b11, 32'h0000_4444);
    idle(32'h0040_0090);
    pc_if = 32'h0040_0090; Wrt = 1; equal = 1; branch_target = 32'h0000_8888;
    #2;
    reset_n = 0;
    #1;
    check("arst_hp", {30'd0, Hp}, 32'd0);
    check("arst_pt", pred_target, 32'h0040_0094);
    check("arst_hpd", {30'd0, Hpd}, 32'd0);
    check("arst_pc_id", pc_id, 32'd0);
    check("arst_cnt", {16'd0, flush_count}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1; Wrt = 0;
    reset_model();
    peek("post_reset", 32'h0040_0090, 2'b00, 32'h0040_0094);
    idle(32'h0040_0090);
    idle(32'h0040_0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
